// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs 1-cycle RAM words with their PC.
// Optional perf counters are enabled with FETCH_PERF_COUNTERS_EN.
module fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_enable,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] imem_pc,
    output logic                  imem_flush,
    input  logic [31:0]           imem_instruction,
    output logic [31:0]           if_instruction,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_valid,
    output logic                  fetch_misaligned_exception
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_f;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  valid_d;
    logic                  aligned;

    assign aligned = (redirect_target[1:0] == 2'b00);

    // Re-present the held address while stalled so the RAM word stays put.
    assign imem_pc        = (stall && valid_d) ? pc_d : pc_f;
    assign imem_flush     = redirect && (state == RUN);
    assign if_instruction = valid_d ? imem_instruction : 32'h0;
    assign if_pc          = pc_d;
    assign if_valid       = valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= IDLE;
            pc_f                       <= RESET_VECTOR;
            pc_d                       <= RESET_VECTOR;
            valid_d                    <= 1'b0;
            fetch_misaligned_exception <= 1'b0;
        end else begin
            fetch_misaligned_exception <= 1'b0;
            unique case (state)
                IDLE: begin
                    valid_d <= 1'b0;
                    if (redirect && aligned)
                        pc_f <= redirect_target;
                    if (fetch_enable)
                        state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        valid_d <= 1'b0;
                        if (aligned) begin
                            pc_f <= redirect_target;
                        end else begin
                            fetch_misaligned_exception <= 1'b1;
                            state                      <= HALTED;
                        end
                    end else if (!stall) begin
                        pc_d    <= pc_f;
                        valid_d <= 1'b1;
                        pc_f    <= pc_f + ADDR_WIDTH'(4);
                    end
                end
                HALTED: begin
                    valid_d <= 1'b0;
                    if (redirect) begin
                        if (aligned) begin
                            pc_f  <= redirect_target;
                            state <= RUN;
                        end else begin
                            fetch_misaligned_exception <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_d <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= 32'h0;
            perf_stall_cycles <= 32'h0;
        end else begin
            if (valid_d && !stall && !redirect)
                perf_fetched <= perf_fetched + 32'h1;
            if (valid_d && stall && !redirect)
                perf_stall_cycles <= perf_stall_cycles + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle-latency instruction RAM model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_enable = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] imem_pc;
    logic        imem_flush;
    logic [31:0] imem_instruction = 32'h0;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        exc;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    int n_tests = 0;
    int n_fail = 0;

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .fetch_enable(fetch_enable),
        .stall(stall),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_pc(imem_pc),
        .imem_flush(imem_flush),
        .imem_instruction(imem_instruction),
        .if_instruction(if_instruction),
        .if_pc(if_pc),
        .if_valid(if_valid),
        .fetch_misaligned_exception(exc)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    always @(posedge clk) imem_instruction <= word(imem_pc);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        #1;
        n_tests++; if (imem_pc !== 32'h0) begin n_fail++; $display("FAIL rst_imem_pc: got %h want %h", imem_pc, 32'h0); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_tests++; if (if_instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", if_instruction); end
        n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        n_tests++; if (exc !== 1'b0) begin n_fail++; $display("FAIL rst_exc: got %b want 0", exc); end
        n_tests++; if (imem_flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", imem_flush); end
`ifdef FETCH_PERF_COUNTERS_EN
        n_tests++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL rst_perf_fetched: got %h want 0", perf_fetched); end
        n_tests++; if (perf_stall_cycles !== 32'h0) begin n_fail++; $display("FAIL rst_perf_stall: got %h want 0", perf_stall_cycles); end
`endif
        reset = 1'b0;
        tick;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", if_valid); end
    endtask

    task automatic test_fetch;
        fetch_enable = 1'b1;
        tick;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_lat1_valid: got %b want 0", if_valid); end
        tick;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL fetch_pc%0d: got %h/%b want %h/1", i, if_pc, if_valid, 32'(4 * i)); end
            n_tests++; if (if_instruction !== word(32'(4 * i))) begin n_fail++; $display("FAIL fetch_instr%0d: got %h want %h", i, if_instruction, word(32'(4 * i))); end
            if (i < 2) tick;
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (imem_pc !== 32'h8) begin n_fail++; $display("FAIL stall_imem_pc%0d: got %h want 8", k, imem_pc); end
            n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc%0d: got %h/%b want 8/1", k, if_pc, if_valid); end
            n_tests++; if (if_instruction !== word(32'h8)) begin n_fail++; $display("FAIL stall_instr%0d: got %h want %h", k, if_instruction, word(32'h8)); end
            tick;
        end
        stall = 1'b0;
        #1;
        n_tests++; if (if_pc !== 32'h8) begin n_fail++; $display("FAIL stall_release_hold: got %h want 8", if_pc); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'hC) begin n_fail++; $display("FAIL stall_next: got %h/%b want c/1", if_pc, if_valid); end
        n_tests++; if (if_instruction !== word(32'hC)) begin n_fail++; $display("FAIL stall_next_instr: got %h want %h", if_instruction, word(32'hC)); end
        tick;
    endtask

    task automatic test_redirect;
        n_tests++; if (if_pc !== 32'h10) begin n_fail++; $display("FAIL redir_pre_pc: got %h want 10", if_pc); end
        redirect = 1'b1;
        redirect_target = 32'h40;
        #1;
        n_tests++; if (imem_flush !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got %b want 1", imem_flush); end
        tick;
        redirect = 1'b0;
        #1;
        n_tests++; if (if_valid !== 1'b0 || imem_flush !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: valid %b flush %b want 0/0", if_valid, imem_flush); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_fail++; $display("FAIL redir_pc40: got %h/%b want 40/1", if_pc, if_valid); end
        n_tests++; if (if_instruction !== word(32'h40)) begin n_fail++; $display("FAIL redir_instr40: got %h want %h", if_instruction, word(32'h40)); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h44) begin n_fail++; $display("FAIL redir_pc44: got %h/%b want 44/1", if_pc, if_valid); end
    endtask

    task automatic test_misaligned;
        redirect = 1'b1;
        redirect_target = 32'h42;
        #1;
        n_tests++; if (imem_flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush: got %b want 1", imem_flush); end
        tick;
        redirect = 1'b0;
        stall = 1'b1;
        #1;
        n_tests++; if (exc !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: exc %b valid %b want 1/0", exc, if_valid); end
        tick;
        n_tests++; if (exc !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_after: exc %b valid %b want 0/0", exc, if_valid); end
        stall = 1'b0;
        redirect = 1'b1;
        redirect_target = 32'h43;
        tick;
        redirect = 1'b0;
        #1;
        n_tests++; if (exc !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_repulse: exc %b valid %b want 1/0", exc, if_valid); end
        tick;
        n_tests++; if (exc !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_halted: exc %b valid %b want 0/0", exc, if_valid); end
        redirect = 1'b1;
        redirect_target = 32'h80;
        tick;
        redirect = 1'b0;
        #1;
        n_tests++; if (if_valid !== 1'b0 || exc !== 1'b0) begin n_fail++; $display("FAIL mis_resume_bubble: valid %b exc %b want 0/0", if_valid, exc); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin n_fail++; $display("FAIL mis_resume_pc: got %h/%b want 80/1", if_pc, if_valid); end
        n_tests++; if (if_instruction !== word(32'h80)) begin n_fail++; $display("FAIL mis_resume_instr: got %h want %h", if_instruction, word(32'h80)); end
    endtask

    task automatic test_stall_redirect;
        stall = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h100;
        #1;
        n_tests++; if (imem_flush !== 1'b1) begin n_fail++; $display("FAIL sr_flush: got %b want 1", imem_flush); end
        tick;
        stall = 1'b0;
        redirect = 1'b0;
        #1;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL sr_bubble: got %b want 0", if_valid); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_fail++; $display("FAIL sr_pc: got %h/%b want 100/1", if_pc, if_valid); end
    endtask

    task automatic test_wrap;
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick;
        redirect = 1'b0;
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h/%b want fffffffc/1", if_pc, if_valid); end
        n_tests++; if (if_instruction !== word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_top_instr: got %h want %h", if_instruction, word(32'hFFFF_FFFC)); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || exc !== 1'b0) begin n_fail++; $display("FAIL wrap_zero: got %h/%b exc %b want 0/1/0", if_pc, if_valid, exc); end
        n_tests++; if (if_instruction !== word(32'h0)) begin n_fail++; $display("FAIL wrap_zero_instr: got %h want %h", if_instruction, word(32'h0)); end
    endtask

    task automatic test_reset_mid_stall;
        stall = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h200;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        fetch_enable = 1'b0;
        #1;
        n_tests++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || imem_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid: valid %b if_pc %h imem_pc %h want 0/0/0", if_valid, if_pc, imem_pc); end
        redirect = 1'b1;
        redirect_target = 32'h300;
        tick;
        redirect = 1'b0;
        #1;
        n_tests++; if (if_valid !== 1'b0 || imem_pc !== 32'h300) begin n_fail++; $display("FAIL idle_redir: valid %b imem_pc %h want 0/300", if_valid, imem_pc); end
        fetch_enable = 1'b1;
        tick;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL idle_start_lat: got %b want 0", if_valid); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h300) begin n_fail++; $display("FAIL idle_start_pc: got %h/%b want 300/1", if_pc, if_valid); end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_stall;
        test_redirect;
        test_misaligned;
        test_stall_redirect;
        test_wrap;
        test_reset_mid_stall;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
